imem_ts_buffer: RTL
===================

// Module: imem_ts_buffer
// PURPOSE
//   Clocked, parametrised input-feature-map memory for the SNN accelerator.
//   Replaces the two-timestep CSP imem.
//   - Holds NUM_TS binary ifmaps of DEPTH_I x DEPTH_I spikes, loaded bit-serially.
//   - Serves whole-row spike vectors to PEs as 33-bit NoC packets.
//   - Sits between the host loader and the mesh router port at node MY_NODE.
// PARAMETERS
//   NUM_TS    2   number of timesteps stored (>=1)
//   DEPTH_I   25  ifmap side length; one row fits one data field (DEPTH_I<=DATA_W)
//   ADDR_W    4   packet address field width, bits [32:29]
//   OPC_W     4   packet opcode field width, bits [28:25]
//   DATA_W    25  packet data field width, bits [24:0]
//   MY_NODE   11  this block's NoC address; used as source in ERR packets
// PORTS
//   clk       in   1        clock, all logic on rising edge
//   reset     in   1        asynchronous, active-high reset
//   load_start in  1        1-cycle pulse: enter LOAD phase
//   ld_valid  in   1        load beat valid
//   ld_ready  out  1        load beat accepted when ld_valid&ld_ready
//   ld_ts     in   $clog2(NUM_TS)+1   timestep of beat
//   ld_addr   in   $clog2(DEPTH_I*DEPTH_I)+1  linear pixel index, row-major
//   ld_bit    in   1        spike value
//   load_done in   1        1-cycle pulse: end LOAD phase
//   rin_valid in   1        router request valid
//   rin_ready out  1        router request accepted when rin_valid&rin_ready
//   rin_pkt   in   33       {addr,opcode,data}
//   rout_valid out 1        response packet valid
//   rout_ready in  1        downstream accepts response
//   rout_pkt  out  33       response {addr,opcode,data}
//   cur_ts    out  $clog2(NUM_TS)+1   timestep currently served
//   all_done  out  1        high after last timestep retired
// BEHAVIOUR
//   Reset: state=IDLE; ld_ready, rin_ready, rout_valid, all_done = 0.
//     rout_pkt=0, cur_ts=0. Spike storage is NOT cleared (flop array, no reset).
//   FSM IDLE -> LOAD on load_start. LOAD: ld_ready=1.
//     Beat with ld_ts<NUM_TS and ld_addr<DEPTH_I^2 writes mem[ld_ts][ld_addr].
//     Out-of-range beats are consumed and discarded.
//   LOAD -> WAIT on load_done. A beat in the same cycle as load_done is still written.
//   WAIT: rin_ready=1. Opcode 0 (START) -> SERVE, cur_ts=0. Other opcodes dropped.
//   SERVE: rin_ready=1 only when no response is pending.
//     Opcode 1 READ_ROW: r=data[4:0], requester=addr field.
//       Response registered 1 cycle after accept.
//       r<DEPTH_I: rout_pkt={requester,4'd2,row r of cur_ts}.
//         Bit c of data = pixel (r,c); bits >= DEPTH_I are 0.
//       r>=DEPTH_I: rout_pkt={requester,4'd3,DATA_W'(MY_NODE)} (ERR).
//     Opcode 10 TS_DONE: cur_ts+1.
//       If cur_ts==NUM_TS-1 -> DONE, all_done=1, cur_ts holds.
//     Any other opcode: consumed, dropped.
//   SEND: rout_valid held with rout_pkt stable until rout_ready, then back to SERVE.
//     rin_ready=0 throughout SEND, so at most one response is outstanding.
//   DONE: rin_ready=1, all packets dropped. load_start -> LOAD, all_done=0, cur_ts=0.
//   Pulse rules:
//     - load_start outside IDLE/DONE is ignored.
//     - load_done outside LOAD is ignored.
//   Asynchronous reset mid-SEND drops the pending packet: rout_valid falls immediately.
// CONFIGURATION
//   IMEM_DROP_CNT_EN defined:
//     - adds port drop_cnt out 8: saturating count (stops at 255) of dropped router
//       packets and discarded load beats.
//     - cleared by reset and by load_start.
//   IMEM_DROP_CNT_EN undefined: port and counter absent; behaviour otherwise identical.
// TESTING
//   1. Load ts0 with pixel(0,c)=c[0], ts1 all ones; START; READ_ROW r=0 from addr 5
//      -> rout_pkt={4'd5,4'd2,25'h0AAAAAA} one cycle after accept.
//   2. TS_DONE then READ_ROW r=3 addr 7 -> {4'd7,4'd2,25'h1FFFFFF}.
//      Second TS_DONE -> all_done=1.
//   3. READ_ROW r=25 -> {addr,4'd3,25'd11}; with IMEM_DROP_CNT_EN, drop_cnt unchanged.
//   4. Hold rout_ready=0 for 10 cycles -> rout_pkt stable, rin_ready=0.
//      Release -> single handshake, rin_ready=1 next cycle.
//   5. Beats with ld_addr=625 and ld_ts=2 -> memory unchanged.
//      With IMEM_DROP_CNT_EN, drop_cnt=2.
//   6. Assert reset during SEND -> rout_valid=0, state IDLE, cur_ts=0 without clk edge.
//      Reload not required: a READ_ROW after load_start/load_done/START returns old data.

Source files
------------

// File: rtl/imem_ts_buffer.sv
// Input-feature-map buffer: stores NUM_TS spike maps loaded bit-serially and serves whole rows as NoC packets.
// Latency: a READ_ROW response is valid on the cycle after the request is accepted; load beats write on acceptance.
// Backpressure: at most one response outstanding; rin_ready stays low while rout_valid waits for rout_ready.
// Optional feature: define IMEM_DROP_CNT_EN to add the 8-bit saturating drop_cnt output.
module imem_ts_buffer #(
    parameter int NUM_TS  = 2,
    parameter int DEPTH_I = 25,
    parameter int ADDR_W  = 4,
    parameter int OPC_W   = 4,
    parameter int DATA_W  = 25,
    parameter int MY_NODE = 11
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_start,
    input  logic                               ld_valid,
    output logic                               ld_ready,
    input  logic [$clog2(NUM_TS):0]            ld_ts,
    input  logic [$clog2(DEPTH_I*DEPTH_I):0]   ld_addr,
    input  logic                               ld_bit,
    input  logic                               load_done,
    input  logic                               rin_valid,
    output logic                               rin_ready,
    input  logic [ADDR_W+OPC_W+DATA_W-1:0]     rin_pkt,
    output logic                               rout_valid,
    input  logic                               rout_ready,
    output logic [ADDR_W+OPC_W+DATA_W-1:0]     rout_pkt,
    output logic [$clog2(NUM_TS):0]            cur_ts,
    output logic                               all_done
`ifdef IMEM_DROP_CNT_EN
    ,
    output logic [7:0]                         drop_cnt
`endif
);

    localparam int TS_W   = $clog2(NUM_TS) + 1;
    localparam int LA_W   = $clog2(DEPTH_I*DEPTH_I) + 1;
    localparam int PIX    = DEPTH_I * DEPTH_I;
    localparam int PIX_IW = $clog2(PIX);
    localparam int TS_IW  = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
    localparam int PKT_W  = ADDR_W + OPC_W + DATA_W;
    localparam int ROW_W  = 5;

    localparam logic [31:0]       DEPTH_U     = 32'(DEPTH_I);
    localparam logic [LA_W-1:0]   PIX_LIM     = LA_W'(PIX);
    localparam logic [TS_W-1:0]   TS_LIM      = TS_W'(NUM_TS);
    localparam logic [TS_W-1:0]   TS_LAST     = TS_W'(NUM_TS - 1);
    localparam logic [OPC_W-1:0]  OPC_START   = OPC_W'(0);
    localparam logic [OPC_W-1:0]  OPC_READ    = OPC_W'(1);
    localparam logic [OPC_W-1:0]  OPC_ROW     = OPC_W'(2);
    localparam logic [OPC_W-1:0]  OPC_ERR     = OPC_W'(3);
    localparam logic [OPC_W-1:0]  OPC_TS_DONE = OPC_W'(10);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SERVE,
        S_SEND,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [TS_W-1:0]     cur_ts_nxt;
    logic [PKT_W-1:0]    pkt_nxt;

    // Spike storage: one flat row-major bit vector per timestep, never reset.
    logic [PIX-1:0]      mem [NUM_TS];

    logic [ADDR_W-1:0]   rin_addr;
    logic [OPC_W-1:0]    rin_opc;
    logic [ROW_W-1:0]    rin_row;
    logic                row_ok;
    logic [PIX_IW-1:0]   row_base;
    logic [DEPTH_I-1:0]  row_vec;
    logic [TS_IW-1:0]    cur_idx;
    logic [TS_IW-1:0]    ld_ts_idx;
    logic [PIX_IW-1:0]   pix_idx;
    logic                ld_in_range;
    logic                unused_data;

    assign rin_addr    = rin_pkt[PKT_W-1 -: ADDR_W];
    assign rin_opc     = rin_pkt[DATA_W +: OPC_W];
    assign rin_row     = rin_pkt[ROW_W-1:0];
    assign unused_data = ^rin_pkt[DATA_W-1:ROW_W];

    assign row_ok      = (32'(rin_row) < DEPTH_U);
    assign row_base    = row_ok ? PIX_IW'(32'(rin_row) * DEPTH_U) : '0;
    assign cur_idx     = cur_ts[TS_IW-1:0];
    assign row_vec     = mem[cur_idx][row_base +: DEPTH_I];

    assign ld_in_range = (ld_ts < TS_LIM) && (ld_addr < PIX_LIM);
    assign ld_ts_idx   = ld_ts[TS_IW-1:0];
    assign pix_idx     = ld_addr[PIX_IW-1:0];

    // Next-state, handshake outputs and response formation
    always_comb begin
        state_nxt  = state;
        cur_ts_nxt = cur_ts;
        pkt_nxt    = rout_pkt;
        ld_ready   = 1'b0;
        rin_ready  = 1'b0;
        rout_valid = 1'b0;
        all_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (load_done) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                rin_ready = 1'b1;
                if (rin_valid && rin_opc == OPC_START) begin
                    state_nxt  = S_SERVE;
                    cur_ts_nxt = '0;
                end
            end
            S_SERVE: begin
                rin_ready = 1'b1;
                if (rin_valid) begin
                    if (rin_opc == OPC_READ) begin
                        state_nxt = S_SEND;
                        if (row_ok) begin
                            pkt_nxt = {rin_addr, OPC_ROW, DATA_W'(row_vec)};
                        end else begin
                            pkt_nxt = {rin_addr, OPC_ERR, DATA_W'(MY_NODE)};
                        end
                    end else if (rin_opc == OPC_TS_DONE) begin
                        if (cur_ts == TS_LAST) begin
                            state_nxt = S_DONE;
                        end else begin
                            cur_ts_nxt = cur_ts + TS_W'(1);
                        end
                    end
                end
            end
            S_SEND: begin
                rout_valid = 1'b1;
                if (rout_ready) begin
                    state_nxt = S_SERVE;
                end
            end
            S_DONE: begin
                rin_ready = 1'b1;
                all_done  = 1'b1;
                if (load_start) begin
                    state_nxt  = S_LOAD;
                    cur_ts_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, served timestep and registered response packet
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cur_ts   <= '0;
            rout_pkt <= '0;
        end else begin
            state    <= state_nxt;
            cur_ts   <= cur_ts_nxt;
            rout_pkt <= pkt_nxt;
        end
    end

    // Write accepted in-range load beats into the spike store
    always_ff @(posedge clk) begin
        if (ld_ready && ld_valid && ld_in_range) begin
            mem[ld_ts_idx][pix_idx] <= ld_bit;
        end
    end

`ifdef IMEM_DROP_CNT_EN
    logic rin_drop;
    logic drop_evt;
    logic cnt_clr;

    // Classify an accepted router packet as dropped for the current state
    always_comb begin
        rin_drop = 1'b0;
        case (state)
            S_WAIT:  rin_drop = (rin_opc != OPC_START);
            S_SERVE: rin_drop = (rin_opc != OPC_READ) && (rin_opc != OPC_TS_DONE);
            S_DONE:  rin_drop = 1'b1;
            default: rin_drop = 1'b0;
        endcase
    end

    assign drop_evt = (rin_valid && rin_ready && rin_drop) ||
                      (ld_valid && ld_ready && !ld_in_range);
    assign cnt_clr  = load_start && (state == S_IDLE || state == S_DONE);

    // Saturating drop counter, restarted with each new load phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (cnt_clr) begin
            drop_cnt <= '0;
        end else if (drop_evt && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule
